ctrl_vector_sequencer: RTL and testbench
========================================

// Module: ctrl_vector_sequencer
// PURPOSE
//  Programmable replay engine for datapath control words. Replaces hand-set bench control with a loadable table.
//  Each table entry holds a control word, a hold count and masked expected ALU flags.
//  Plays entries to the single-cycle datapath in run, single-step or loop mode, and counts flag mismatches.
//  Sits between a host/bench load port and the datapath control inputs.
// PARAMETERS
//  CTRL_W  13  control word width; LSB-first fields: ImmSrc[1:0], RegSrc[3:2], RegWrite[4], ALUSrc[5], PCSrc[6], ALUControl[10:7], MemtoReg[11], MemWrite[12]
//  DEPTH   16  table entries (power of 2); AW = $clog2(DEPTH)
//  HOLD_W  4   hold-count width; an entry with hold count h is driven for h+1 cycles
//  CNT_W   8   width of the mismatch and loop counters
// PORTS
//  clk           in   1                   rising-edge clock
//  reset         in   1                   synchronous, active-high
//  load_en       in   1                   write one table entry this cycle
//  load_addr     in   AW                  entry index
//  load_data     in   CTRL_W+HOLD_W+8     {exp_flags[3:0], flag_mask[3:0], hold, ctrl}
//  seq_len       in   AW+1                entries to play, 1..DEPTH; sampled at start
//  mode          in   2                   00 run, 01 single-step, 10 loop, 11 = run; sampled at start
//  start         in   1                   pulse: begin sequence
//  step          in   1                   pulse: advance from PAUSE
//  abort         in   1                   return to IDLE
//  flags_in      in   4                   datapath ALU flags {N,Z,C,V}
//  ctrl_out      out  CTRL_W              registered control word to the datapath
//  busy          out  1                   high in RUN or PAUSE
//  done          out  1                   high in DONE
//  entry_idx     out  AW                  index of the entry currently driven
//  mismatch_cnt  out  CNT_W               saturating count of flag mismatches
//  first_err_idx out  AW                  index of the first mismatching entry
//  err_valid     out  1                   at least one mismatch since start
//  loop_cnt      out  CNT_W               completed passes in loop mode; wraps
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0. Table contents are not reset.
//  ctrl_out = 0 is a NOP (no MemWrite, no RegWrite, no PCSrc).
//  Table: register array, combinational read.
//   - Writes are accepted only in IDLE or DONE; load_en in RUN or PAUSE is ignored.
//  States: IDLE, RUN, PAUSE, DONE.
//  IDLE/DONE + start (no load_en that cycle):
//   - seq_len == 0 or seq_len > DEPTH -> DONE.
//   - Otherwise -> RUN. Next edge: ptr = 0, ctrl_out = mem[0].ctrl, hold_cnt = mem[0].hold.
//   - Clears mismatch_cnt, err_valid, first_err_idx, loop_cnt; latches seq_len and mode.
//  start and load_en in the same cycle: the load wins and start is ignored.
//  RUN, each edge:
//   - hold_cnt != 0 -> hold_cnt - 1; ctrl_out held.
//   - hold_cnt == 0 (last cycle of the entry): compare ((flags_in ^ exp_flags) & flag_mask) != 0.
//   - On mismatch: mismatch_cnt +1, saturating at all-ones. On the first mismatch only: err_valid = 1, first_err_idx = ptr.
//  After the last cycle of an entry:
//   - Not the last entry, mode run/loop: ptr + 1, load the next entry the same edge; no bubble.
//   - Not the last entry, single-step: -> PAUSE, ctrl_out = 0.
//   - Last entry (ptr == seq_len-1), run or single-step: -> DONE, ctrl_out = 0.
//   - Last entry, loop: ptr = 0, reload mem[0], loop_cnt + 1 (wraps); stays in RUN.
//  PAUSE: ctrl_out = 0, entry_idx = ptr of the finished entry. On step: ptr + 1, load that entry, -> RUN.
//  abort (any state) -> IDLE, ctrl_out = 0 next edge. Counters keep their values.
//  Priority: reset > abort > start > step.
//   - start is ignored in RUN and PAUSE.
//   - step is ignored outside PAUSE.
//  done stays high until start, abort or reset.
// TESTING
//  1. Load 3 entries ctrl {0x0193, 0x0013, 0x1000}, hold 0, mask 0; seq_len 3, run
//     -> the three words on consecutive cycles, then 0; done rises on the 4th edge.
//  2. Entry 0 hold 3, mask 4'b0100, exp Z = 1, flags_in = 0
//     -> ctrl held 4 cycles; mismatch_cnt 1, first_err_idx 0, err_valid 1.
//  3. Single-step, seq_len 2 -> ctrl_out 0 in PAUSE; step -> entry 1 driven the next cycle; step pulses in RUN ignored.
//  4. Loop, seq_len 2, hold 0, run 10 cycles then abort
//     -> loop_cnt 5, ctrl_out 0 the next cycle, state IDLE.
//  5. load_en during RUN: table unchanged; start with seq_len 0 -> done with ctrl_out 0.
//     Saturation: 300 mismatches with CNT_W 8 -> mismatch_cnt 255.
//  6. reset asserted mid-RUN -> all outputs 0 next edge; start + load_en in the same cycle -> load done, no start.

Source files
------------

// File: rtl/ctrl_vector_sequencer.sv
// rtl/ctrl_vector_sequencer.sv - table-driven replay of datapath control words with flag checking
module ctrl_vector_sequencer #(
  parameter int CTRL_W = 13,
  parameter int DEPTH  = 16,
  parameter int HOLD_W = 4,
  parameter int CNT_W  = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LD_W  = CTRL_W + HOLD_W + 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [AW-1:0]     load_addr,
  input  logic [LD_W-1:0]   load_data,
  input  logic [AW:0]       seq_len,
  input  logic [1:0]        mode,
  input  logic              start,
  input  logic              step,
  input  logic              abort,
  input  logic [3:0]        flags_in,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     entry_idx,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic [AW-1:0]     first_err_idx,
  output logic              err_valid,
  output logic [CNT_W-1:0]  loop_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int HOLD_LSB = CTRL_W;
  localparam int MASK_LSB = CTRL_W + HOLD_W;
  localparam int EXP_LSB  = MASK_LSB + 4;

  localparam logic [AW:0] MAX_LEN = (AW+1)'(DEPTH);

  logic [LD_W-1:0]   mem [DEPTH];
  logic [1:0]        state;
  logic [AW-1:0]     ptr;
  logic [HOLD_W-1:0] hold_cnt;
  logic [AW:0]       len_q;
  logic [1:0]        mode_q;

  logic [LD_W-1:0]   cur_entry;
  logic [LD_W-1:0]   nxt_entry;
  logic [LD_W-1:0]   first_entry;
  logic [AW-1:0]     nxt_ptr;
  logic              idle_or_done;
  logic              load_ok;
  logic              start_ok;
  logic              len_ok;
  logic              is_last;
  logic              flag_err;
  logic              loop_mode;
  logic              step_mode;

  assign idle_or_done = (state == IDLE) || (state == DONE);
  assign load_ok      = load_en && idle_or_done;
  // A simultaneous load takes the cycle; start must be re-issued afterwards.
  assign start_ok     = start && !load_en && idle_or_done;
  assign len_ok       = (seq_len != '0) && (seq_len <= MAX_LEN);

  assign nxt_ptr      = ptr + 1'b1;
  assign cur_entry    = mem[ptr];
  assign nxt_entry    = mem[nxt_ptr];
  assign first_entry  = mem[0];

  assign is_last      = ({1'b0, ptr} == (len_q - 1'b1));
  assign flag_err     = |((flags_in ^ cur_entry[EXP_LSB +: 4]) & cur_entry[MASK_LSB +: 4]);
  assign loop_mode    = (mode_q == 2'b10);
  assign step_mode    = (mode_q == 2'b01);

  assign busy         = (state == RUN) || (state == PAUSE);
  assign done         = (state == DONE);
  assign entry_idx    = ptr;

  always_ff @(posedge clk) begin
    if (load_ok) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      ptr           <= '0;
      hold_cnt      <= '0;
      len_q         <= '0;
      mode_q        <= 2'b00;
      ctrl_out      <= '0;
      mismatch_cnt  <= '0;
      first_err_idx <= '0;
      err_valid     <= 1'b0;
      loop_cnt      <= '0;
    end else if (abort) begin
      state    <= IDLE;
      ctrl_out <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            mismatch_cnt  <= '0;
            first_err_idx <= '0;
            err_valid     <= 1'b0;
            loop_cnt      <= '0;
            len_q         <= seq_len;
            mode_q        <= mode;
            ptr           <= '0;
            if (len_ok) begin
              state    <= RUN;
              ctrl_out <= first_entry[CTRL_W-1:0];
              hold_cnt <= first_entry[HOLD_LSB +: HOLD_W];
            end else begin
              state    <= DONE;
              ctrl_out <= '0;
              hold_cnt <= '0;
            end
          end
        end
        RUN: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
          end else begin
            // Flags are judged only on the final cycle of an entry.
            if (flag_err) begin
              if (mismatch_cnt != '1) begin
                mismatch_cnt <= mismatch_cnt + 1'b1;
              end
              if (!err_valid) begin
                err_valid     <= 1'b1;
                first_err_idx <= ptr;
              end
            end
            if (is_last) begin
              if (loop_mode) begin
                ptr      <= '0;
                ctrl_out <= first_entry[CTRL_W-1:0];
                hold_cnt <= first_entry[HOLD_LSB +: HOLD_W];
                loop_cnt <= loop_cnt + 1'b1;
              end else begin
                state    <= DONE;
                ctrl_out <= '0;
              end
            end else if (step_mode) begin
              state    <= PAUSE;
              ctrl_out <= '0;
            end else begin
              ptr      <= nxt_ptr;
              ctrl_out <= nxt_entry[CTRL_W-1:0];
              hold_cnt <= nxt_entry[HOLD_LSB +: HOLD_W];
            end
          end
        end
        PAUSE: begin
          if (step) begin
            state    <= RUN;
            ptr      <= nxt_ptr;
            ctrl_out <= nxt_entry[CTRL_W-1:0];
            hold_cnt <= nxt_entry[HOLD_LSB +: HOLD_W];
          end
        end
        default: begin
          state    <= IDLE;
          ctrl_out <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_vector_sequencer.sv
// tb/tb_ctrl_vector_sequencer.sv - directed bench for ctrl_vector_sequencer
module tb_ctrl_vector_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [24:0] load_data;
  logic [4:0]  seq_len;
  logic [1:0]  mode;
  logic        start;
  logic        step;
  logic        abort;
  logic [3:0]  flags_in;
  logic [12:0] ctrl_out;
  logic        busy;
  logic        done;
  logic [3:0]  entry_idx;
  logic [7:0]  mismatch_cnt;
  logic [3:0]  first_err_idx;
  logic        err_valid;
  logic [7:0]  loop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  ctrl_vector_sequencer dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .seq_len(seq_len), .mode(mode), .start(start),
    .step(step), .abort(abort), .flags_in(flags_in), .ctrl_out(ctrl_out),
    .busy(busy), .done(done), .entry_idx(entry_idx), .mismatch_cnt(mismatch_cnt),
    .first_err_idx(first_err_idx), .err_valid(err_valid), .loop_cnt(loop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_entry(input logic [3:0] addr, input logic [3:0] expf,
                            input logic [3:0] mask, input logic [3:0] hold,
                            input logic [12:0] ctrl);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = {expf, mask, hold, ctrl};
    tick();
    load_en   = 1'b0;
  endtask

  task automatic start_seq(input logic [4:0] len, input logic [1:0] md);
    seq_len = len;
    mode    = md;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_cmp++; if (ctrl_out !== 13'h0) begin n_err++; $display("FAIL rst_ctrl got=%h exp=0", ctrl_out); end
    n_cmp++; if ({busy, done, err_valid} !== 3'b000) begin n_err++; $display("FAIL rst_status got=%b exp=000", {busy, done, err_valid}); end
    n_cmp++; if ({entry_idx, first_err_idx, mismatch_cnt, loop_cnt} !== 24'h0) begin n_err++; $display("FAIL rst_counters got=%h exp=0", {entry_idx, first_err_idx, mismatch_cnt, loop_cnt}); end
  endtask

  task automatic test_run();
    flags_in = 4'h0;
    load_entry(4'd0, 4'h0, 4'h0, 4'h0, 13'h0193);
    load_entry(4'd1, 4'h0, 4'h0, 4'h0, 13'h0013);
    load_entry(4'd2, 4'h0, 4'h0, 4'h0, 13'h1000);
    start_seq(5'd3, 2'b00);
    n_cmp++; if (ctrl_out !== 13'h0193 || busy !== 1'b1) begin n_err++; $display("FAIL run_e0 got=%h/%b exp=0193/1", ctrl_out, busy); end
    tick();
    n_cmp++; if (ctrl_out !== 13'h0013 || entry_idx !== 4'd1) begin n_err++; $display("FAIL run_e1 got=%h/%0d exp=0013/1", ctrl_out, entry_idx); end
    tick();
    n_cmp++; if (ctrl_out !== 13'h1000 || done !== 1'b0) begin n_err++; $display("FAIL run_e2 got=%h/%b exp=1000/0", ctrl_out, done); end
    tick();
    n_cmp++; if (ctrl_out !== 13'h0 || done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL run_done got=%h/%b/%b exp=0/1/0", ctrl_out, done, busy); end
    tick();
    n_cmp++; if (done !== 1'b1 || mismatch_cnt !== 8'd0) begin n_err++; $display("FAIL run_done_hold got=%b/%0d exp=1/0", done, mismatch_cnt); end
  endtask

  task automatic test_hold_mismatch();
    int held = 0;
    flags_in = 4'h0;
    load_entry(4'd0, 4'b0100, 4'b0100, 4'd3, 13'h0ABC);
    start_seq(5'd1, 2'b00);
    for (int i = 0; i < 4; i++) begin
      if (ctrl_out === 13'h0ABC) held++;
      n_cmp++; if (mismatch_cnt !== 8'd0) begin n_err++; $display("FAIL hold_early_cnt cyc=%0d got=%0d exp=0", i, mismatch_cnt); end
      tick();
    end
    n_cmp++; if (held !== 4) begin n_err++; $display("FAIL hold_cycles got=%0d exp=4", held); end
    n_cmp++; if (ctrl_out !== 13'h0 || done !== 1'b1) begin n_err++; $display("FAIL hold_done got=%h/%b exp=0/1", ctrl_out, done); end
    n_cmp++; if (mismatch_cnt !== 8'd1 || first_err_idx !== 4'd0 || err_valid !== 1'b1) begin n_err++; $display("FAIL hold_err got=%0d/%0d/%b exp=1/0/1", mismatch_cnt, first_err_idx, err_valid); end
  endtask

  task automatic test_first_err();
    flags_in = 4'h0;
    load_entry(4'd0, 4'b0000, 4'b1111, 4'h0, 13'h0001);
    load_entry(4'd1, 4'b0001, 4'b0001, 4'h0, 13'h0002);
    load_entry(4'd2, 4'b1000, 4'b1000, 4'h0, 13'h0003);
    start_seq(5'd3, 2'b11);
    tick();
    tick();
    tick();
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL ferr_done got=%b exp=1", done); end
    n_cmp++; if (mismatch_cnt !== 8'd2 || first_err_idx !== 4'd1 || err_valid !== 1'b1) begin n_err++; $display("FAIL ferr_err got=%0d/%0d/%b exp=2/1/1", mismatch_cnt, first_err_idx, err_valid); end
  endtask

  task automatic test_single_step();
    flags_in = 4'h0;
    load_entry(4'd0, 4'h0, 4'h0, 4'd0, 13'h0011);
    load_entry(4'd1, 4'h0, 4'h0, 4'd2, 13'h0022);
    start_seq(5'd2, 2'b01);
    n_cmp++; if (ctrl_out !== 13'h0011) begin n_err++; $display("FAIL step_e0 got=%h exp=0011", ctrl_out); end
    tick();
    n_cmp++; if (ctrl_out !== 13'h0 || busy !== 1'b1 || entry_idx !== 4'd0) begin n_err++; $display("FAIL step_pause got=%h/%b/%0d exp=0/1/0", ctrl_out, busy, entry_idx); end
    tick();
    n_cmp++; if (ctrl_out !== 13'h0 || entry_idx !== 4'd0 || done !== 1'b0) begin n_err++; $display("FAIL step_wait got=%h/%0d/%b exp=0/0/0", ctrl_out, entry_idx, done); end
    step = 1'b1;
    tick();
    step = 1'b0;
    n_cmp++; if (ctrl_out !== 13'h0022 || entry_idx !== 4'd1) begin n_err++; $display("FAIL step_e1 got=%h/%0d exp=0022/1", ctrl_out, entry_idx); end
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    n_cmp++; if (ctrl_out !== 13'h0022 || busy !== 1'b1) begin n_err++; $display("FAIL step_ignored got=%h/%b exp=0022/1", ctrl_out, busy); end
    tick();
    n_cmp++; if (ctrl_out !== 13'h0 || done !== 1'b1) begin n_err++; $display("FAIL step_done got=%h/%b exp=0/1", ctrl_out, done); end
  endtask

  task automatic test_loop_abort();
    flags_in = 4'h0;
    load_entry(4'd0, 4'h0, 4'h0, 4'd0, 13'h0101);
    load_entry(4'd1, 4'h0, 4'h0, 4'd0, 13'h0202);
    start_seq(5'd2, 2'b10);
    repeat (10) tick();
    n_cmp++; if (loop_cnt !== 8'd5 || ctrl_out !== 13'h0101 || busy !== 1'b1) begin n_err++; $display("FAIL loop_run got=%0d/%h/%b exp=5/0101/1", loop_cnt, ctrl_out, busy); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++; if (ctrl_out !== 13'h0 || busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL loop_abort got=%h/%b/%b exp=0/0/0", ctrl_out, busy, done); end
    n_cmp++; if (loop_cnt !== 8'd5) begin n_err++; $display("FAIL loop_cnt_kept got=%0d exp=5", loop_cnt); end
  endtask

  task automatic test_load_guard();
    int waited = 0;
    flags_in = 4'h0;
    load_entry(4'd0, 4'h0, 4'h0, 4'd5, 13'h0555);
    start_seq(5'd1, 2'b00);
    load_entry(4'd0, 4'h0, 4'h0, 4'd0, 13'h0AAA);
    while (done !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL guard_timeout got=%b exp=1", done); end
    start_seq(5'd1, 2'b00);
    n_cmp++; if (ctrl_out !== 13'h0555) begin n_err++; $display("FAIL guard_table got=%h exp=0555", ctrl_out); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    start_seq(5'd0, 2'b00);
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || ctrl_out !== 13'h0) begin n_err++; $display("FAIL len0 got=%b/%b/%h exp=1/0/0", done, busy, ctrl_out); end
    start_seq(5'd17, 2'b00);
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL len17 got=%b/%b exp=1/0", done, busy); end
  endtask

  task automatic test_saturation();
    load_entry(4'd0, 4'h0, 4'hF, 4'd0, 13'h0007);
    flags_in = 4'hF;
    start_seq(5'd1, 2'b10);
    repeat (300) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++; if (mismatch_cnt !== 8'd255) begin n_err++; $display("FAIL sat_cnt got=%0d exp=255", mismatch_cnt); end
    n_cmp++; if (loop_cnt !== 8'd44) begin n_err++; $display("FAIL sat_loop_wrap got=%0d exp=44", loop_cnt); end
    n_cmp++; if (err_valid !== 1'b1 || first_err_idx !== 4'd0) begin n_err++; $display("FAIL sat_err got=%b/%0d exp=1/0", err_valid, first_err_idx); end
    flags_in = 4'h0;
    start_seq(5'd1, 2'b00);
    n_cmp++; if (mismatch_cnt !== 8'd0 || loop_cnt !== 8'd0 || err_valid !== 1'b0) begin n_err++; $display("FAIL sat_clear got=%0d/%0d/%b exp=0/0/0", mismatch_cnt, loop_cnt, err_valid); end
    tick();
  endtask

  task automatic test_reset_and_collision();
    load_entry(4'd0, 4'h0, 4'hF, 4'd0, 13'h0333);
    flags_in = 4'hF;
    start_seq(5'd1, 2'b10);
    repeat (3) tick();
    n_cmp++; if (busy !== 1'b1 || mismatch_cnt !== 8'd3 || loop_cnt !== 8'd3) begin n_err++; $display("FAIL mid_run got=%b/%0d/%0d exp=1/3/3", busy, mismatch_cnt, loop_cnt); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    flags_in = 4'h0;
    n_cmp++; if (ctrl_out !== 13'h0 || {busy, done, err_valid} !== 3'b000) begin n_err++; $display("FAIL mid_reset got=%h/%b exp=0/000", ctrl_out, {busy, done, err_valid}); end
    n_cmp++; if ({entry_idx, first_err_idx, mismatch_cnt, loop_cnt} !== 24'h0) begin n_err++; $display("FAIL mid_reset_cnt got=%h exp=0", {entry_idx, first_err_idx, mismatch_cnt, loop_cnt}); end
    load_en   = 1'b1;
    load_addr = 4'd0;
    load_data = {4'h0, 4'h0, 4'h0, 13'h0444};
    seq_len   = 5'd1;
    mode      = 2'b00;
    start     = 1'b1;
    tick();
    load_en   = 1'b0;
    start     = 1'b0;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || ctrl_out !== 13'h0) begin n_err++; $display("FAIL collide_nostart got=%b/%b/%h exp=0/0/0", busy, done, ctrl_out); end
    start_seq(5'd1, 2'b00);
    n_cmp++; if (ctrl_out !== 13'h0444) begin n_err++; $display("FAIL collide_loaded got=%h exp=0444", ctrl_out); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    seq_len   = '0;
    mode      = 2'b00;
    start     = 1'b0;
    step      = 1'b0;
    abort     = 1'b0;
    flags_in  = 4'h0;
    test_reset();
    test_run();
    test_hold_mismatch();
    test_first_err();
    test_single_step();
    test_loop_abort();
    test_load_guard();
    test_saturation();
    test_reset_and_collision();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
